rhs_spi_master: RTL
===================

Name: rhs_spi_master

Overview:
- SPI controller that drives the RHS headstage interface: generates CS, SCLK and MOSI and captures MISO.
- Accepts one command word per frame through a valid/ready handshake.
- Shifts the command out MSB-first while shifting the reply in, then presents the reply with a one-cycle valid strobe.
- Sits between the acquisition sequencer and the pads, and pairs directly with the existing RHS SPI device model in simulation.

Parameters:
- WORD_W, 32, bits per frame (command and reply width).
- CLK_DIV, 2, clk cycles per SCLK half-period; legal values are 1 or more.
- CS_SETUP, 2, clk cycles of CS low before the first SCLK rise, and again after the last SCLK fall.
- CS_HIGH, 4, minimum clk cycles CS stays high between frames.
- TAG_W, 8, width of the command tag.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active-high.
- cmd_valid  in  1  command word present.
- cmd_ready  out  1  block can accept a command.
- cmd_data  in  WORD_W  command word, sent MSB first.
- cmd_tag  in  TAG_W  user tag associated with the command.
- rx_valid  out  1  one-cycle strobe: reply word available.
- rx_data  out  WORD_W  reply word captured during the frame just ended.
- rx_tag  out  TAG_W  tag of the command this reply answers.
- rx_tag_valid  out  1  rx_tag is meaningful.
- busy  out  1  frame in progress (any state except IDLE).
- CS  out  1  chip select, active-low.
- SCLK  out  1  serial clock, idle low (CPOL=0).
- MOSI  out  1  serial data to device.
- MISO  in  1  serial data from device.

Behaviour:
- Reset (rst=1 at a clk edge):
  - CS=1, SCLK=0, MOSI=0, cmd_ready=0, rx_valid=0, rx_data=0, rx_tag=0, rx_tag_valid=0, busy=0.
  - State goes to IDLE and all counters clear.
  - Reset mid-frame aborts the frame: CS rises on that edge, no rx_valid, the command is discarded.
- States: IDLE, SETUP, XFER, HOLD, GAP.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid&&cmd_ready: latch cmd_data and cmd_tag; next cycle enter SETUP with CS=0, MOSI=cmd_data[WORD_W-1], cmd_ready=0, busy=1.
- SETUP:
  - Hold CS=0 and SCLK=0 for CS_SETUP cycles, then enter XFER.
- XFER:
  - Each bit has CLK_DIV cycles with SCLK=0, then CLK_DIV cycles with SCLK=1.
  - The device samples MOSI on the SCLK rise.
  - MISO is sampled into the shift register on the clk edge that ends the SCLK-high phase; SCLK falls on that same edge.
  - MOSI advances to the next bit on that same edge.
  - After bit 0's high phase ends, enter HOLD with SCLK=0.
- HOLD:
  - CS=0 for CS_SETUP cycles.
  - On exit: CS=1, rx_data=shift register, rx_valid=1 for exactly that one cycle; enter GAP.
- GAP:
  - CS=1 for CS_HIGH cycles, then IDLE with cmd_ready=1.
- Frame timing:
  - CS low for exactly 2*CS_SETUP + 2*WORD_W*CLK_DIV cycles.
  - Accept-to-rx_valid = 1 + that count.
  - Accept-to-next-cmd_ready = 1 + that count + CS_HIGH.
- Back-to-back commands: cmd_valid held high is accepted on the first IDLE cycle; no other accepts occur.
- cmd_data changes while busy are ignored, because the latched copy is used.
- rx_data holds its value until the next rx_valid.
- MOSI holds the last bit (bit 0) until the next accept, then takes the new MSB.

Optional Feature:
- Macro: RHS_SPI_PIPE_TAG_EN.
- Enabled (the device answers each command two frames later):
  - A 2-deep tag pipeline advances at each rx_valid.
  - rx_tag = tag of the command issued two frames before the current one.
  - rx_tag_valid=0 for the first two frames after reset, then 1 alongside rx_valid.
- Disabled:
  - No pipeline; rx_tag=0 and rx_tag_valid=0 always.

Test Plan:
- Reset then single command 0xA5A5_0F0F; bench MISO model returns 0x1234_0000 → MOSI bit sequence matches the command MSB-first, CS low for exactly 132 cycles (defaults), rx_valid one pulse with rx_data=0x1234_0000, SCLK makes exactly 32 rising edges.
- cmd_valid held high with 3 commands queued → accepts are spaced 137 cycles apart, CS high ≥4 cycles between frames, no extra SCLK edges while CS=1.
- Assert rst at SCLK edge 10 of a frame → CS=1 and SCLK=0 at the next edge, no rx_valid, the next command after reset transfers correctly.
- CLK_DIV=1, CS_SETUP=1 with MISO walking-ones pattern 0x8000_0001 → rx_data=0x8000_0001, CS low for 66 cycles.
- RHS_SPI_PIPE_TAG_EN defined, tags 1,2,3,4 → rx_tag_valid=0,0,1,1 and rx_tag=x,x,1,2; undefined → rx_tag=0 and rx_tag_valid=0 throughout.
- cmd_data toggled mid-frame → transmitted bits unchanged from the value at accept.

Source files
------------

// File: rtl/rhs_spi_master.sv
// rhs_spi_master: SPI master (CPOL=0) for the RHS headstage. One command word
// per CS frame, shifted out MSB-first while the reply is shifted in from MISO.
// Optional build macro RHS_SPI_PIPE_TAG_EN enables a 2-deep tag pipeline that
// pairs each reply with the command issued two frames earlier.
module rhs_spi_master #(
  parameter int unsigned WORD_W   = 32,
  parameter int unsigned CLK_DIV  = 2,
  parameter int unsigned CS_SETUP = 2,
  parameter int unsigned CS_HIGH  = 4,
  parameter int unsigned TAG_W    = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [WORD_W-1:0] cmd_data,
  input  logic [TAG_W-1:0]  cmd_tag,
  output logic              rx_valid,
  output logic [WORD_W-1:0] rx_data,
  output logic [TAG_W-1:0]  rx_tag,
  output logic              rx_tag_valid,
  output logic              busy,
  output logic              CS,
  output logic              SCLK,
  output logic              MOSI,
  input  logic              MISO
);

  localparam int unsigned CNT_W = 16;
  localparam int unsigned BIT_W = $clog2(WORD_W) + 1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_XFER,
    ST_HOLD,
    ST_GAP
  } state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [BIT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic [WORD_W-1:0] tx_sh_q, tx_sh_d;
  logic [WORD_W-1:0] rx_sh_q, rx_sh_d;
  logic              cs_q, cs_d;
  logic              sclk_q, sclk_d;
  logic              mosi_q, mosi_d;
  logic              cmd_ready_q, cmd_ready_d;
  logic              rx_valid_q, rx_valid_d;
  logic [WORD_W-1:0] rx_data_q, rx_data_d;
  logic              busy_q, busy_d;

  logic [WORD_W-1:0] tx_shl;
  logic [WORD_W-1:0] rx_shl;

`ifdef RHS_SPI_PIPE_TAG_EN
  logic [TAG_W-1:0]  cur_tag_q, cur_tag_d;
  logic [TAG_W-1:0]  pipe1_q, pipe1_d;
  logic [TAG_W-1:0]  pipe2_q, pipe2_d;
  logic [1:0]        fill_q, fill_d;
  logic [TAG_W-1:0]  rx_tag_q, rx_tag_d;
  logic              rx_tag_valid_q, rx_tag_valid_d;
`endif

  // Shift helpers: next MOSI word and MISO capture
  assign tx_shl = tx_sh_q << 1;
  assign rx_shl = (rx_sh_q << 1) | WORD_W'(MISO);

  // Next-state and next-output computation for the frame sequencer
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    bit_cnt_d   = bit_cnt_q;
    tx_sh_d     = tx_sh_q;
    rx_sh_d     = rx_sh_q;
    cs_d        = cs_q;
    sclk_d      = sclk_q;
    mosi_d      = mosi_q;
    cmd_ready_d = cmd_ready_q;
    rx_valid_d  = 1'b0;
    rx_data_d   = rx_data_q;
    busy_d      = busy_q;
`ifdef RHS_SPI_PIPE_TAG_EN
    cur_tag_d      = cur_tag_q;
    pipe1_d        = pipe1_q;
    pipe2_d        = pipe2_q;
    fill_d         = fill_q;
    rx_tag_d       = rx_tag_q;
    rx_tag_valid_d = 1'b0;
`endif

    unique case (state_q)
      ST_IDLE: begin
        cmd_ready_d = 1'b1;
        busy_d      = 1'b0;
        if (cmd_valid && cmd_ready_q) begin
          tx_sh_d     = cmd_data;
          mosi_d      = cmd_data[WORD_W-1];
          cs_d        = 1'b0;
          cmd_ready_d = 1'b0;
          busy_d      = 1'b1;
          cnt_d       = '0;
          state_d     = ST_SETUP;
`ifdef RHS_SPI_PIPE_TAG_EN
          cur_tag_d   = cmd_tag;
`endif
        end
      end

      ST_SETUP: begin
        if (cnt_q == CNT_W'(CS_SETUP - 1)) begin
          cnt_d     = '0;
          bit_cnt_d = '0;
          state_d   = ST_XFER;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      ST_XFER: begin
        if (cnt_q == CNT_W'(CLK_DIV - 1)) begin
          cnt_d = '0;
          if (!sclk_q) begin
            sclk_d = 1'b1;
          end else begin
            // End of high phase: capture MISO, drop SCLK, advance MOSI
            sclk_d  = 1'b0;
            rx_sh_d = rx_shl;
            if (bit_cnt_q == BIT_W'(WORD_W - 1)) begin
              state_d = ST_HOLD;
            end else begin
              bit_cnt_d = bit_cnt_q + BIT_W'(1);
              tx_sh_d   = tx_shl;
              mosi_d    = tx_shl[WORD_W-1];
            end
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      ST_HOLD: begin
        if (cnt_q == CNT_W'(CS_SETUP - 1)) begin
          cnt_d      = '0;
          cs_d       = 1'b1;
          rx_valid_d = 1'b1;
          rx_data_d  = rx_sh_q;
          state_d    = ST_GAP;
`ifdef RHS_SPI_PIPE_TAG_EN
          pipe1_d        = cur_tag_q;
          pipe2_d        = pipe1_q;
          rx_tag_d       = pipe2_q;
          rx_tag_valid_d = (fill_q == 2'd2);
          if (fill_q != 2'd2) begin
            fill_d = fill_q + 2'd1;
          end
`endif
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      ST_GAP: begin
        if (cnt_q == CNT_W'(CS_HIGH - 1)) begin
          cnt_d       = '0;
          cmd_ready_d = 1'b1;
          busy_d      = 1'b0;
          state_d     = ST_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers with synchronous reset (aborts any frame)
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      bit_cnt_q   <= '0;
      tx_sh_q     <= '0;
      rx_sh_q     <= '0;
      cs_q        <= 1'b1;
      sclk_q      <= 1'b0;
      mosi_q      <= 1'b0;
      cmd_ready_q <= 1'b0;
      rx_valid_q  <= 1'b0;
      rx_data_q   <= '0;
      busy_q      <= 1'b0;
`ifdef RHS_SPI_PIPE_TAG_EN
      cur_tag_q      <= '0;
      pipe1_q        <= '0;
      pipe2_q        <= '0;
      fill_q         <= '0;
      rx_tag_q       <= '0;
      rx_tag_valid_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      tx_sh_q     <= tx_sh_d;
      rx_sh_q     <= rx_sh_d;
      cs_q        <= cs_d;
      sclk_q      <= sclk_d;
      mosi_q      <= mosi_d;
      cmd_ready_q <= cmd_ready_d;
      rx_valid_q  <= rx_valid_d;
      rx_data_q   <= rx_data_d;
      busy_q      <= busy_d;
`ifdef RHS_SPI_PIPE_TAG_EN
      cur_tag_q      <= cur_tag_d;
      pipe1_q        <= pipe1_d;
      pipe2_q        <= pipe2_d;
      fill_q         <= fill_d;
      rx_tag_q       <= rx_tag_d;
      rx_tag_valid_q <= rx_tag_valid_d;
`endif
    end
  end

  assign CS        = cs_q;
  assign SCLK      = sclk_q;
  assign MOSI      = mosi_q;
  assign cmd_ready = cmd_ready_q;
  assign rx_valid  = rx_valid_q;
  assign rx_data   = rx_data_q;
  assign busy      = busy_q;

`ifdef RHS_SPI_PIPE_TAG_EN
  assign rx_tag       = rx_tag_q;
  assign rx_tag_valid = rx_tag_valid_q;
`else
  // Without the pipeline the tag input is intentionally ignored
  logic unused_cmd_tag;
  assign unused_cmd_tag = ^cmd_tag;
  assign rx_tag         = '0;
  assign rx_tag_valid   = 1'b0;
`endif

endmodule
